// File: rtl/ram_arb_pkg.sv
// Shared encodings for the two-master ram arbiter: FSM states and master indices.
package ram_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int unsigned M0    = 0;
  localparam int unsigned M1    = 1;
  localparam int unsigned NUM_M = 2;

endpackage

// File: rtl/ram_arb_grant.sv
// One-hot grant select for two masters; a held lock overrides any new arbitration.
// Fixed priority (m1 highest) by default; round-robin on ptr_i when RAM_ARB_RR_EN is defined.
module ram_arb_grant
  import ram_arb_pkg::*;
(
  input  logic [NUM_M-1:0] req_i,
  input  logic             ptr_i,
  input  logic [NUM_M-1:0] lock_i,
  output logic [NUM_M-1:0] gnt_o
);

`ifndef RAM_ARB_RR_EN
  logic unused_ptr;
  assign unused_ptr = ptr_i;
`endif

  always_comb begin
    gnt_o = '0;
    if (|lock_i) begin
      gnt_o = lock_i;
    end
`ifdef RAM_ARB_RR_EN
    else if (req_i == 2'b11) begin
      gnt_o = ptr_i ? 2'b10 : 2'b01;
    end
`else
    else if (req_i[M1]) begin
      gnt_o = 2'b10;
    end
`endif
    else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/ram_arb.sv
// Two-master ram arbiter, one transaction outstanding, zero added latency on request/response paths.
// Stalled requests lock the grant until accepted; RAM_ARB_RR_EN selects round-robin over fixed priority.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_data_i,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_req_valid_i,
  output logic          m0_req_ready_o,
  output logic          m0_rsp_valid_o,
  input  logic          m0_rsp_ready_i,
  output logic [DW-1:0] m0_data_o,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_data_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_req_valid_i,
  output logic          m1_req_ready_o,
  output logic          m1_rsp_valid_o,
  input  logic          m1_rsp_ready_i,
  output logic [DW-1:0] m1_data_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_data_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  input  logic [DW-1:0] s_data_i,
  output logic          s_req_valid_o,
  input  logic          s_req_ready_i,
  input  logic          s_rsp_valid_i,
  output logic          s_rsp_ready_o
);

  state_e           state_q;
  logic             owner_q;
  logic [NUM_M-1:0] lock_q, lock_d;
  logic [NUM_M-1:0] req, gnt;
  logic             ptr;
  logic             idle, busy, req_hs, rsp_hs, rsp_fwd;

`ifdef RAM_ARB_RR_EN
  logic ptr_q;
  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  assign req  = {m1_req_valid_i, m0_req_valid_i};
  assign idle = (state_q == ST_IDLE);
  assign busy = (state_q == ST_BUSY);

  ram_arb_grant u_grant (
    .req_i  (req),
    .ptr_i  (ptr),
    .lock_i (lock_q),
    .gnt_o  (gnt)
  );

  // Request side: granted master's payload passes straight through while idle.
  assign s_addr_o       = gnt[M1] ? m1_addr_i : m0_addr_i;
  assign s_data_o       = gnt[M1] ? m1_data_i : m0_data_i;
  assign s_sel_o        = gnt[M1] ? m1_sel_i  : m0_sel_i;
  assign s_we_o         = gnt[M1] ? m1_we_i   : m0_we_i;
  assign s_req_valid_o  = idle && |(gnt & req);
  assign m0_req_ready_o = idle && gnt[M0] && s_req_ready_i;
  assign m1_req_ready_o = idle && gnt[M1] && s_req_ready_i;
  assign req_hs         = s_req_valid_o && s_req_ready_i;

  // Response side: only the owner sees the slave; gated in reset so an abandoned beat is dropped.
  assign rsp_fwd        = busy && !rst && s_rsp_valid_i;
  assign s_rsp_ready_o  = busy && !rst && (owner_q ? m1_rsp_ready_i : m0_rsp_ready_i);
  assign m0_rsp_valid_o = rsp_fwd && !owner_q;
  assign m1_rsp_valid_o = rsp_fwd &&  owner_q;
  assign m0_data_o      = (rsp_fwd && !owner_q) ? s_data_i : '0;
  assign m1_data_o      = (rsp_fwd &&  owner_q) ? s_data_i : '0;
  assign rsp_hs         = s_rsp_valid_i && s_rsp_ready_o;

  assign lock_d = (s_req_valid_o && !s_req_ready_i) ? gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      lock_q  <= '0;
`ifdef RAM_ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      lock_q <= lock_d;
      if (state_q == ST_IDLE) begin
        if (req_hs) begin
          state_q <= ST_BUSY;
          owner_q <= gnt[M1];
`ifdef RAM_ARB_RR_EN
          ptr_q   <= ~ptr_q;
`endif
        end
      end else if (rsp_hs) begin
        state_q <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb: combinational IDLE vector table plus multi-cycle handshake sequences.
module tb_ram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m1_we_i;
  logic        m0_req_valid_i, m0_req_ready_o, m0_rsp_valid_o, m0_rsp_ready_i;
  logic        m1_req_valid_i, m1_req_ready_o, m1_rsp_valid_o, m1_rsp_ready_i;
  logic [31:0] m0_data_o, m1_data_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_req_valid_o, s_req_ready_i, s_rsp_valid_i, s_rsp_ready_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_arb dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o),
    .m0_rsp_valid_o(m0_rsp_valid_o), .m0_rsp_ready_i(m0_rsp_ready_i), .m0_data_o(m0_data_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o),
    .m1_rsp_valid_o(m1_rsp_valid_o), .m1_rsp_ready_i(m1_rsp_ready_i), .m1_data_o(m1_data_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_data_i(s_data_i), .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i),
    .s_rsp_valid_i(s_rsp_valid_i), .s_rsp_ready_o(s_rsp_ready_o)
  );

  typedef struct {
    logic        v0, v1, rdy;
    logic        sv, r0, r1;
    logic [31:0] addr;
    logic        we;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m0_addr_i = 32'h10; m0_data_i = 32'hDEADBEEF; m0_sel_i = 4'hF; m0_we_i = 1'b1;
    m1_addr_i = 32'h20; m1_data_i = 32'h12345678; m1_sel_i = 4'h3; m1_we_i = 1'b0;
    m0_req_valid_i = 1'b0; m1_req_valid_i = 1'b0;
    m0_rsp_ready_i = 1'b0; m1_rsp_ready_i = 1'b0;
    s_req_ready_i = 1'b0; s_rsp_valid_i = 1'b0; s_data_i = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic exp_m[4];

    //            v0    v1    rdy   sv    r0    r1    addr    we
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1};
`ifdef RAM_ARB_RR_EN
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1};
    exp_m   = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 1'b0};
    exp_m   = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Reset state, with a stray slave response that must be ignored in IDLE.
    do_reset();
    s_rsp_valid_i = 1'b1; m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("rst s_req_valid", s_req_valid_o, 0);
    chk("rst m0_req_ready", m0_req_ready_o, 0);
    chk("rst m1_req_ready", m1_req_ready_o, 0);
    chk("rst m0_rsp_valid", m0_rsp_valid_o, 0);
    chk("rst m1_rsp_valid", m1_rsp_valid_o, 0);
    chk("rst s_rsp_ready", s_rsp_ready_o, 0);

    // Combinational IDLE behaviour, fresh reset before each vector.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      m0_req_valid_i = vecs[i].v0; m1_req_valid_i = vecs[i].v1; s_req_ready_i = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d s_req_valid", i), s_req_valid_o, vecs[i].sv);
      chk($sformatf("vec%0d m0_req_ready", i), m0_req_ready_o, vecs[i].r0);
      chk($sformatf("vec%0d m1_req_ready", i), m1_req_ready_o, vecs[i].r1);
      if (vecs[i].sv) begin
        chk($sformatf("vec%0d s_addr", i), s_addr_o, vecs[i].addr);
        chk($sformatf("vec%0d s_we", i), s_we_o, vecs[i].we);
      end
    end

    // m0 alone writes, response next cycle; no new accept in the response cycle.
    do_reset();
    m0_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
    @(negedge clk);
    chk("wr s_we", s_we_o, 1);
    chk("wr s_addr", s_addr_o, 32'h10);
    chk("wr s_data", s_data_o, 32'hDEADBEEF);
    chk("wr s_sel", s_sel_o, 4'hF);
    chk("wr m0_req_ready", m0_req_ready_o, 1);
    step();
    s_rsp_valid_i = 1'b1; s_data_i = 32'h0BADF00D; m0_rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("wr m0_rsp_valid", m0_rsp_valid_o, 1);
    chk("wr m0_data", m0_data_o, 32'h0BADF00D);
    chk("wr m1_rsp_valid", m1_rsp_valid_o, 0);
    chk("wr m1_data", m1_data_o, 0);
    chk("wr s_rsp_ready", s_rsp_ready_o, 1);
    chk("wr busy m0_req_ready", m0_req_ready_o, 0);
    chk("wr busy s_req_valid", s_req_valid_o, 0);
    step();
    s_rsp_valid_i = 1'b0;
    @(negedge clk);
    chk("wr next m0_req_ready", m0_req_ready_o, 1);

`ifndef RAM_ARB_RR_EN
    // Fixed priority: m1 first, m0 after m1's response completes.
    do_reset();
    m0_req_valid_i = 1'b1; m1_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
    @(negedge clk);
    chk("fp m1_req_ready", m1_req_ready_o, 1);
    chk("fp m0_req_ready", m0_req_ready_o, 0);
    chk("fp s_addr", s_addr_o, 32'h20);
    step();
    m1_req_valid_i = 1'b0; s_rsp_valid_i = 1'b1; s_data_i = 32'h11112222; m1_rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("fp m1_rsp_valid", m1_rsp_valid_o, 1);
    chk("fp m1_data", m1_data_o, 32'h11112222);
    chk("fp busy m0_req_ready", m0_req_ready_o, 0);
    step();
    s_rsp_valid_i = 1'b0;
    @(negedge clk);
    chk("fp m0 served", m0_req_ready_o, 1);
    chk("fp m0 s_addr", s_addr_o, 32'h10);
`endif

    // Lock: m0 stalls 3 cycles while m1 is also valid; grant must not move.
    do_reset();
    m0_req_valid_i = 1'b1; s_req_ready_i = 1'b0;
    @(negedge clk);
    chk("lk s_req_valid", s_req_valid_o, 1);
    chk("lk m0_req_ready", m0_req_ready_o, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      m1_req_valid_i = 1'b1;
      @(negedge clk);
      chk($sformatf("lk c%0d s_addr", k), s_addr_o, 32'h10);
    end
    step();
    s_req_ready_i = 1'b1;
    @(negedge clk);
    chk("lk m0_req_ready", m0_req_ready_o, 1);
    chk("lk m1_req_ready", m1_req_ready_o, 0);
    step();
    m0_req_valid_i = 1'b0; s_rsp_valid_i = 1'b1; s_data_i = 32'h33334444; m0_rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("lk m0_rsp_valid", m0_rsp_valid_o, 1);
    step();
    s_rsp_valid_i = 1'b0;
    @(negedge clk);
    chk("lk m1 next", m1_req_ready_o, 1);

    // Response backpressure from m1 for 2 cycles, delivered on the third.
    do_reset();
    m1_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
    @(negedge clk);
    chk("bp m1_req_ready", m1_req_ready_o, 1);
    step();
    m1_req_valid_i = 1'b0; m0_req_valid_i = 1'b1;
    s_rsp_valid_i = 1'b1; s_data_i = 32'hA5A5A5A5; m1_rsp_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("bp c%0d s_rsp_ready", k), s_rsp_ready_o, 0);
      chk($sformatf("bp c%0d m0_rsp_valid", k), m0_rsp_valid_o, 0);
      chk($sformatf("bp c%0d m0_data", k), m0_data_o, 0);
      chk($sformatf("bp c%0d m0_req_ready", k), m0_req_ready_o, 0);
      chk($sformatf("bp c%0d m1_rsp_valid", k), m1_rsp_valid_o, 1);
      step();
    end
    m1_rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp m1_data", m1_data_o, 32'hA5A5A5A5);
    chk("bp s_rsp_ready", s_rsp_ready_o, 1);
    step();
    s_rsp_valid_i = 1'b0;
    @(negedge clk);
    chk("bp m0 next", m0_req_ready_o, 1);

    // Reset while BUSY abandons the transaction.
    do_reset();
    m0_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
    step();
    m0_req_valid_i = 1'b0; s_rsp_valid_i = 1'b1; m0_rsp_ready_i = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rb rst m0_rsp_valid", m0_rsp_valid_o, 0);
    step();
    rst = 1'b0; m1_req_valid_i = 1'b1;
    @(negedge clk);
    chk("rb m0_rsp_valid", m0_rsp_valid_o, 0);
    chk("rb m1_rsp_valid", m1_rsp_valid_o, 0);
    chk("rb s_rsp_ready", s_rsp_ready_o, 0);
    chk("rb m1_req_ready", m1_req_ready_o, 1);
    chk("rb s_addr", s_addr_o, 32'h20);

    // Both masters valid continuously for 4 transactions.
    do_reset();
    m0_req_valid_i = 1'b1; m1_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
    m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      s_rsp_valid_i = 1'b0;
      @(negedge clk);
      chk($sformatf("seq t%0d m0_req_ready", t), m0_req_ready_o, !exp_m[t]);
      chk($sformatf("seq t%0d m1_req_ready", t), m1_req_ready_o, exp_m[t]);
      step();
      s_rsp_valid_i = 1'b1;
      @(negedge clk);
      chk($sformatf("seq t%0d m1_rsp_valid", t), m1_rsp_valid_o, exp_m[t]);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 SHALL have parameter AW, default 32, the address width.
REQ-002 SHALL have parameter DW, default 32, the data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL, for each master N in {0,1}, have ports mN_addr_i in AW, mN_data_i in DW, mN_sel_i in 4 and mN_we_i in 1: the request payload.
REQ-006 SHALL, for each master N, have ports mN_req_valid_i in 1, mN_req_ready_o out 1, mN_rsp_valid_o out 1, mN_rsp_ready_i in 1 and mN_data_o out DW.
REQ-007 SHALL have slave-side ports s_addr_o out AW, s_data_o out DW, s_sel_o out 4, s_we_o out 1 and s_data_i in DW: the ram payload and read data.
REQ-008 SHALL have slave-side ports s_req_valid_o out 1, s_req_ready_i in 1, s_rsp_valid_i in 1 and s_rsp_ready_o out 1: the ram handshake.

Function
REQ-009 SHALL arbitrate two masters onto one ram port with at most one transaction outstanding.
REQ-010 SHALL use a two-state FSM: IDLE moves to BUSY on a slave request handshake (s_req_valid_o && s_req_ready_i); BUSY moves to IDLE on a slave response handshake (s_rsp_valid_i && s_rsp_ready_o).
REQ-011 SHALL, in IDLE, drive the granted master's payload and valid combinationally to the slave outputs, and set mN_req_ready_o = grant[N] && s_req_ready_i.
REQ-012 SHALL hold s_req_valid_o, mN_req_ready_o and every non-granted master's ready at 0 while in BUSY.
REQ-013 SHALL, when both masters are valid in IDLE and no lock is held, grant master 1 under fixed priority (see REQ-021).
REQ-014 SHALL set a lock when s_req_valid_o=1 and s_req_ready_i=0, and hold the same grant while locked until the handshake completes; a higher-priority arrival SHALL NOT preempt a locked grant.
REQ-015 SHALL record the owner (granted index) on the request handshake.
REQ-016 SHALL, in BUSY, route s_rsp_valid_i and s_data_i to the owner only, set s_rsp_ready_o = owner's rsp_ready, and drive 0 on the non-owner's rsp_valid and data.
REQ-017 SHALL NOT accept a new request in the cycle of a response handshake; the earliest next request handshake is the following cycle.
REQ-018 SHALL give one-cycle request-to-response latency through the arbiter, with zero added cycles on either path.
REQ-019 SHALL ignore s_rsp_valid_i while in IDLE: it is not forwarded and not acknowledged.

Reset
REQ-020 SHALL, with rst high at a clock edge, set state=IDLE, owner=0, lock=0 and the round-robin pointer to 0; the handshake outputs then follow REQ-011 and REQ-012. Reset during BUSY SHALL abandon the transaction with no response forwarded.

Configuration
REQ-021 SHALL, with macro RAM_ARB_RR_EN defined, use round-robin arbitration: a 1-bit pointer favours the master not served last and toggles on each request handshake. Without the macro, SHALL use fixed priority with master 1 highest and no pointer register.

Structure
REQ-022 SHALL place the state encodings (ST_IDLE, ST_BUSY) and master-index constants in the shared defines file.
REQ-023 SHALL implement grant logic as sub-module ram_arb_grant (inputs: requests, pointer, lock; output: one-hot grant); the FSM and muxing SHALL stay in ram_arb.

Verification
REQ-024 SHALL cover: m0 alone writes addr 0x10, data 0xDEADBEEF, sel 0xF with s_req_ready_i=1 -> s_we_o=1 and s_addr_o=0x10 the same cycle; m0_rsp_valid_o the next cycle.
REQ-025 SHALL cover: both masters valid in IDLE, fixed priority -> m1 granted, m0_req_ready_o=0; m0 served after m1's response completes.
REQ-026 SHALL cover: RAM_ARB_RR_EN defined, both masters valid continuously for 4 transactions -> grant order m0, m1, m0, m1.
REQ-027 SHALL cover: m0 requests with s_req_ready_i=0 for 3 cycles while m1 asserts valid -> grant stays m0 (lock), and m0 is accepted when ready rises.
REQ-028 SHALL cover: response to m1 with m1_rsp_ready_i=0 for 2 cycles -> s_rsp_ready_o=0, state stays BUSY, m0_rsp_valid_o=0, data 0xA5A5A5A5 is delivered on the third cycle.
REQ-029 SHALL cover: rst asserted in BUSY -> next cycle IDLE, every rsp_valid output 0, and a new request is accepted immediately.
